nn_serial_ctrl: RTL and testbench
=================================

Name: nn_serial_ctrl

Overview:
- Time-multiplexed controller/datapath for the 1-input, N_HID-hidden-neuron, 1-output PLL network.
- Replaces the fully parallel evaluation with one shared signed multiply-accumulate unit.
- Sequences weight fetches from an external synchronous weight ROM and drives a single external combinational activation function.
- Exchanges samples with the PLL loop through valid/ready handshakes.

Parameters:
- N_HID, 6, number of hidden neurons.
- W_W, 8, signed weight/bias word width.
- ACC_W, 20, signed accumulator width.
- ADDR_W, 5, ROM address width; must satisfy 2^ADDR_W >= 3*N_HID+2.
- OUT_SHIFT, 8, arithmetic right shift applied to the final accumulator before output saturation.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in1/in2 sample valid.
- in_ready  out  1  controller idle, can accept a sample.
- in1  in  9  signed first-layer input.
- in2  in  9  signed direct second-layer input.
- w_addr  out  ADDR_W  weight ROM address, registered.
- w_data  in  W_W  signed ROM word, valid one cycle after w_addr.
- af_in  out  16  signed pre-activation to the activation function.
- af_out  in  16  activation result, combinational from af_in; bits [8:0] are used.
- out_valid  out  1  out1 valid.
- out_ready  in  1  consumer accepts out1.
- out1  out  8  unsigned network output.
- busy  out  1  high from accept until the output handshake completes.

Behaviour:
- Reset values: in_ready=1, out_valid=0, busy=0, out1=0, w_addr=0, af_in=0, accumulator=0, hidden registers=0, FSM=IDLE.
- Reset asserted mid-operation aborts the sample; nothing is emitted.
- ROM map, words sign-extended:
  - addr 2j = w1_j; addr 2j+1 = b1_j, for j=0..N_HID-1.
  - addr 2*N_HID+j = w2_j.
  - addr 3*N_HID = w2_in2.
  - addr 3*N_HID+1 = b2.
- Accept: in the IDLE state when in_valid&&in_ready.
  - Latch in1 and in2.
  - Drop in_ready and raise busy at the accepting edge.
  - in_valid is ignored while not in IDLE.
- FETCH: w_addr steps 0,1,...,3*N_HID+1, one address per cycle. Strictly incremental, no repeats or skips.
- Each word is consumed the cycle after its address is presented.
- L1 (per neuron j):
  - On w1_j: acc = in1*w1_j.
  - On b1_j: s = sat16(acc+b1_j), driven on af_in in the same cycle.
  - h_j <= af_out[8:0], captured at that edge.
  - sat16 clamps to [-32768, 32767].
- L2:
  - On w2_0: acc = h_0*w2_0, where h_j is signed 9-bit.
  - On each subsequent w2_j: acc += h_j*w2_j.
  - Then acc += in2*w2_in2, then acc += b2.
- af_in holds its last value outside L1 bias cycles.
- OUT: out1 <= clamp(acc >>> OUT_SHIFT, 0, 255); out_valid <= 1.
- Latency: out_valid rises exactly 3*N_HID+4 clock edges after the accepting edge (22 for N_HID=6).
- Output handshake:
  - out_valid and out1 hold stable while out_ready=0.
  - On out_valid&&out_ready: out_valid=0, busy=0, in_ready=1 at that edge, return to IDLE.
  - A new sample can be accepted on the following cycle; there is no overlap of samples.
- If out_ready is already high when out_valid rises, the output is accepted on that cycle's edge.
- FSM states: IDLE -> L1 -> L2 -> OUT -> IDLE.
  - One counter indexes words.
  - L1 lasts 2*N_HID consume cycles; L2 lasts N_HID+2.
- Widths: products are 9x8 -> 17 bits signed. Accumulation is in ACC_W bits; ACC_W=20 cannot overflow for N_HID<=6, so no wrap handling is needed.

Decomposition:
- Shared package nn_pkg holds the ROM map constants:
  - W1_BASE, W2_BASE, WIN2_ADDR, B2_ADDR as functions of N_HID.
  - FSM state encodings.
  - sat16 and clamp_u8 functions.
- One natural sub-module: nn_mac (signed multiply plus accumulate/clear/load, ACC_W wide). The FSM and addressing stay in nn_serial_ctrl.
- Activation function and ROM remain external instances.

Test Plan:
- Nominal, bench af model is identity, OUT_SHIFT=0:
  - Setup: in1=10, in2=3, all w1=2, b1=1, w2=1, w2_in2=4, b2=10.
  - Expect: af_in=21 for each neuron; out1=148; out_valid exactly 22 edges after accept.
- Saturation: in1=-256, w1_0=-128, b1_0=0 -> af_in=32767 in neuron 0's bias cycle.
- Negative output: all weights 0 except b2=-100 -> out1=0. Separately, OUT_SHIFT=0 with acc=300 -> out1=255.
- Backpressure: out_ready held low 10 cycles after out_valid.
  - Expect: out1 and out_valid stable, in_ready=0, second in_valid ignored.
  - Release: handshake accepted, in_ready=1 on the same edge, next sample accepted the cycle after.
- Address trace: log w_addr per cycle from accept.
  - Expect: sequence 0..19 contiguous starting the cycle after accept, then holds.
- Reset mid-op: assert rst at cycle 9 after accept.
  - Expect: all outputs at reset values next edge, no out_valid ever for that sample; the next sample yields the correct result.

Source files
------------

// File: rtl/nn_pkg.sv
// nn_pkg: ROM map, state/op encodings and saturation helpers shared by the serial network
package nn_pkg;

    typedef enum logic [1:0] {S_IDLE, S_L1, S_L2, S_OUT} state_e;
    typedef enum logic [1:0] {MAC_HOLD, MAC_CLR, MAC_LOAD, MAC_ACC} mac_op_e;

    localparam int W1_BASE = 0;

    function automatic int w2_base(input int n);
        return 2 * n;
    endfunction

    function automatic int win2_addr(input int n);
        return 3 * n;
    endfunction

    function automatic int b2_addr(input int n);
        return 3 * n + 1;
    endfunction

    function automatic logic signed [15:0] sat16(input int x);
        return x > 32767 ? 16'sh7fff : x < -32768 ? 16'sh8000 : 16'(x);
    endfunction

    function automatic logic [7:0] clamp_u8(input int x);
        return x > 255 ? 8'hff : x < 0 ? 8'h00 : 8'(x);
    endfunction

endpackage

// File: rtl/nn_mac.sv
// nn_mac: shared signed multiply with clear, load and accumulate into an ACC_W register
module nn_mac
    import nn_pkg::*;
#(
    parameter int A_W   = 9,
    parameter int B_W   = 8,
    parameter int ACC_W = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  mac_op_e                 op_i,
    input  logic signed [A_W-1:0]   a_i,
    input  logic signed [B_W-1:0]   b_i,
    output logic signed [ACC_W-1:0] acc_o
);

    logic signed [A_W+B_W-1:0] prod;
    logic signed [ACC_W-1:0]   acc_d, acc_q;

    assign prod = a_i * b_i;

    always_comb begin
        acc_d = op_i == MAC_CLR  ? '0 :
                op_i == MAC_LOAD ? ACC_W'(prod) :
                op_i == MAC_ACC  ? acc_q + ACC_W'(prod) : acc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else acc_q <= acc_d;
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/nn_serial_ctrl.sv
// nn_serial_ctrl: time-multiplexed 1-N_HID-1 network on one shared MAC, weights from external ROM
module nn_serial_ctrl
    import nn_pkg::*;
#(
    parameter int N_HID     = 6,
    parameter int W_W       = 8,
    parameter int ACC_W     = 20,
    parameter int ADDR_W    = 5,
    parameter int OUT_SHIFT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic signed [8:0]       in1_i,
    input  logic signed [8:0]       in2_i,
    output logic [ADDR_W-1:0]       w_addr_o,
    input  logic signed [W_W-1:0]   w_data_i,
    output logic signed [15:0]      af_in_o,
    input  logic signed [15:0]      af_out_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [7:0]              out1_o,
    output logic                    busy_o
);

    localparam int CNT_W = $clog2(3 * N_HID + 3);
    localparam int HI_W  = N_HID > 1 ? $clog2(N_HID) : 1;
    localparam logic [CNT_W-1:0]  L1_END = CNT_W'(2 * N_HID);
    localparam logic [CNT_W-1:0]  L2_END = CNT_W'(b2_addr(N_HID) + 1);
    localparam logic [CNT_W-1:0]  K_W2   = CNT_W'(w2_base(N_HID));
    localparam logic [CNT_W-1:0]  K_WIN2 = CNT_W'(win2_addr(N_HID));
    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(b2_addr(N_HID));

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q, k;
    logic [ADDR_W-1:0]       w_addr_q;
    logic signed [8:0]       in1_q, in2_q, mac_a;
    logic signed [8:0]       h_q [N_HID];
    logic signed [15:0]      af_q, s;
    logic [7:0]              out1_q;
    logic                    in_ready_q, out_valid_q, busy_q;
    logic                    accept, l1, l1_w, l1_b;
    logic [HI_W-1:0]         j1, j2;
    mac_op_e                 mac_op;
    logic signed [ACC_W-1:0] acc;
    logic                    unused_af;

    // cnt_q counts cycles from accept; the word on w_data_i is ROM word k = cnt_q-1
    assign k      = cnt_q - CNT_W'(1);
    assign accept = state_q == S_IDLE && in_valid_i && in_ready_q;
    assign l1     = state_q == S_L1 && cnt_q != '0;
    assign l1_w   = l1 && !k[0];
    assign l1_b   = l1 && k[0];
    assign j1     = HI_W'((k - CNT_W'(W1_BASE)) >> 1);
    assign j2     = HI_W'(k - K_W2);
    assign s      = sat16(int'(acc) + int'(w_data_i));

    assign af_in_o     = l1_b ? s : af_q;
    assign w_addr_o    = w_addr_q;
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out1_o      = out1_q;
    assign busy_o      = busy_q;
    assign unused_af   = ^af_out_i[15:9];

    always_comb begin
        mac_op = MAC_HOLD;
        mac_a  = in1_q;
        if (accept) mac_op = MAC_CLR;
        else if (l1_w) mac_op = MAC_LOAD;
        else if (state_q == S_L2) begin
            mac_op = k == K_W2 ? MAC_LOAD : MAC_ACC;
            mac_a  = k < K_WIN2 ? h_q[j2] : k == K_WIN2 ? in2_q : 9'sd1;
        end
    end

    nn_mac #(.A_W(9), .B_W(W_W), .ACC_W(ACC_W)) u_mac (
        .clk   (clk),
        .rst   (rst),
        .op_i  (mac_op),
        .a_i   (mac_a),
        .b_i   (w_data_i),
        .acc_o (acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            w_addr_q    <= '0;
            af_q        <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            out1_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < N_HID; i++) h_q[i] <= '0;
        end else begin
            if (state_q == S_L1 || state_q == S_L2) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (w_addr_q != A_LAST) w_addr_q <= w_addr_q + ADDR_W'(1);
            end
            if (l1_b) begin
                af_q     <= s;
                h_q[j1]  <= af_out_i[8:0];
            end
            case (state_q)
                S_IDLE: if (accept) begin
                    in1_q      <= in1_i;
                    in2_q      <= in2_i;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                    w_addr_q   <= '0;
                    cnt_q      <= '0;
                    state_q    <= S_L1;
                end
                S_L1: if (cnt_q == L1_END) state_q <= S_L2;
                S_L2: if (cnt_q == L2_END) state_q <= S_OUT;
                S_OUT: if (!out_valid_q) begin
                    out_valid_q <= 1'b1;
                    out1_q      <= clamp_u8(int'(acc >>> OUT_SHIFT));
                end else if (out_ready_i) begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_serial_ctrl.sv
// tb_nn_serial_ctrl: directed and random samples against an arithmetic model of the network
module tb_nn_serial_ctrl;

    localparam int N    = 6;
    localparam int LAST = 3 * N + 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b1;
    logic signed [8:0]  in1 = '0, in2 = '0;
    logic [4:0]         w_addr;
    logic signed [7:0]  w_data;
    logic signed [15:0] af_in, af_out;
    logic               in_ready, out_valid, busy;
    logic [7:0]         out1;
    logic signed [7:0]  rom [32];

    int total = 0;
    int bad = 0;
    int w1 [N], b1 [N], w2 [N];
    int w2i, b2;
    int exp_s [N];
    int exp_out;

    always #5 clk = ~clk;

    always @(posedge clk) w_data <= rom[w_addr];
    assign af_out = af_in;

    nn_serial_ctrl #(.N_HID(N), .W_W(8), .ACC_W(20), .ADDR_W(5), .OUT_SHIFT(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in1_i       (in1),
        .in2_i       (in2),
        .w_addr_o    (w_addr),
        .w_data_i    (w_data),
        .af_in_o     (af_in),
        .af_out_i    (af_out),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out1_o      (out1),
        .busy_o      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic load_rom();
        for (int j = 0; j < N; j++) begin
            rom[2*j]   = 8'(w1[j]);
            rom[2*j+1] = 8'(b1[j]);
            rom[2*N+j] = 8'(w2[j]);
        end
        rom[3*N]   = 8'(w2i);
        rom[3*N+1] = 8'(b2);
    endtask

    task automatic set_all(input int a, input int b, input int c, input int d, input int e);
        for (int j = 0; j < N; j++) begin
            w1[j] = a;
            b1[j] = b;
            w2[j] = c;
        end
        w2i = d;
        b2  = e;
        load_rom();
    endtask

    task automatic model(input int i1, input int i2);
        int acc, p, h;
        acc = 0;
        for (int j = 0; j < N; j++) begin
            p        = i1 * w1[j] + b1[j];
            exp_s[j] = p > 32767 ? 32767 : p < -32768 ? -32768 : p;
            h        = ((exp_s[j] & 511) ^ 256) - 256;
            acc     += h * w2[j];
        end
        acc    += i2 * w2i + b2;
        exp_out = acc > 255 ? 255 : acc < 0 ? 0 : acc;
    endtask

    // Called at a negedge; returns at the negedge after the output handshake.
    task automatic run(input int i1, input int i2, input int stall, input int g1, input int g2);
        int idx;
        model(i1, i2);
        in_valid  = 1'b1;
        in1       = 9'(i1);
        in2       = 9'(i2);
        out_ready = stall == 0;
        chk("in_ready_idle", in_ready, 1);
        for (int e = 0; e <= 21; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 0) begin
                in_valid = 1'b0;
                chk("in_ready_busy", in_ready, 0);
                chk("busy_set", busy, 1);
            end
            chk("w_addr", w_addr, e < LAST ? e : LAST);
            chk("out_valid_early", out_valid, 0);
            if (e >= 2) begin
                idx = (e - 2) / 2 < N - 1 ? (e - 2) / 2 : N - 1;
                chk("af_in", 32'(af_in), 32'(exp_s[idx]));
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("out_valid_rise", out_valid, 1);
        chk("out1", out1, exp_out);
        if (stall > 0) begin
            in_valid = 1'b1;
            in1      = 9'(g1);
            in2      = 9'(g2);
            for (int c = 0; c < stall; c++) begin
                @(posedge clk);
                @(negedge clk);
                chk("hold_valid", out_valid, 1);
                chk("hold_out1", out1, exp_out);
                chk("hold_in_ready", in_ready, 0);
                chk("hold_busy", busy, 1);
            end
            out_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        chk("hs_out_valid", out_valid, 0);
        chk("hs_in_ready", in_ready, 1);
        chk("hs_busy", busy, 0);
    endtask

    initial begin
        int seen;
        for (int i = 0; i < 32; i++) rom[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out1", out1, 0);
        chk("rst_w_addr", w_addr, 0);
        chk("rst_af_in", 32'(af_in), 0);
        rst = 1'b0;
        @(negedge clk);

        set_all(2, 1, 1, 4, 10);
        run(10, 3, 0, 0, 0);
        chk("nominal_148", out1, 148);

        w1[0] = -128;
        b1[0] = 0;
        load_rom();
        run(-256, 3, 0, 0, 0);
        chk("sat_s0", exp_s[0], 32767);

        set_all(0, 0, 0, 0, -100);
        run(77, -5, 0, 0, 0);
        set_all(0, 0, 0, 3, 0);
        run(-9, 100, 0, 0, 0);

        set_all(2, 1, 1, 4, 10);
        run(10, 3, 10, 5, 7);
        run(5, 7, 0, 0, 0);

        in_valid = 1'b1;
        in1      = 9'sd10;
        in2      = 9'sd3;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out1", out1, 0);
        chk("mid_rst_w_addr", w_addr, 0);
        chk("mid_rst_af_in", 32'(af_in), 0);
        rst  = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("no_out_after_rst", seen, 0);
        run(10, 3, 0, 0, 0);

        for (int t = 0; t < 20; t++) begin
            for (int j = 0; j < N; j++) begin
                w1[j] = int'($urandom_range(0, 255)) - 128;
                b1[j] = int'($urandom_range(0, 255)) - 128;
                w2[j] = int'($urandom_range(0, 255)) - 128;
            end
            w2i = int'($urandom_range(0, 255)) - 128;
            b2  = int'($urandom_range(0, 255)) - 128;
            load_rom();
            run(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 511)) - 256, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
